axi_wr_burst_master: RTL and testbench

- Downstream of the 32-to-64 packing stage. Consumes 64-bit beats through a read-enable source interface and writes them to BRAM/DDR as AXI4 INCR write bursts.
- Software or the game-logic controller issues a start pulse with a base address and a beat count. The block splits the transfer into bursts of at most BURST_LEN beats, then pulses done.

---
 rtl/axi_wr_burst_master_pkg.sv | 18 +
 rtl/axi_wr_burst_master_if.sv | 41 ++++
 rtl/axi_burst_splitter.sv | 45 ++++
 rtl/axi_wr_burst_master.sv | 120 ++++++++++++
 tb/tb_axi_wr_burst_master.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_wr_burst_master_pkg.sv
// rtl/axi_wr_burst_master_pkg.sv - shared AXI constants and FSM state type
package axi_wr_burst_master_pkg;

  localparam logic [2:0] AXSIZE_8B      = 3'b011;
  localparam logic [1:0] BURST_INCR     = 2'b01;
  localparam logic [1:0] RESP_OKAY      = 2'b00;
  localparam logic [7:0] WSTRB_ALL      = 8'hFF;
  localparam int         BYTES_PER_BEAT = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/axi_wr_burst_master_if.sv
// rtl/axi_wr_burst_master_if.sv - AXI4 write-channel bundle (AW, W, B)
interface axi_wr_burst_master_if #(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  logic [63:0]       wdata;
  logic [7:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/axi_burst_splitter.sv
// rtl/axi_burst_splitter.sv - remaining-beat counter, burst address and burst length
module axi_burst_splitter
  import axi_wr_burst_master_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  total_beats,
  output logic [ADDR_W-1:0] addr,
  output logic [8:0]        burst_beats,
  output logic [7:0]        awlen,
  output logic              last_burst
);

  localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);

  logic [CNT_W-1:0] remaining;

  // The final burst carries whatever is left; every earlier one is full length.
  assign last_burst  = (remaining <= BURST_LEN_C);
  assign burst_beats = last_burst ? 9'(remaining) : 9'(BURST_LEN);
  // Idle with nothing remaining reports awlen 0 rather than wrapping to 255.
  assign awlen       = (burst_beats == 9'd0) ? 8'd0 : 8'(burst_beats - 9'd1);

  // Latch the transfer on start, then step past each completed burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= base_addr;
      remaining <= total_beats;
    end else if (advance) begin
      addr      <= addr + ADDR_W'(burst_beats) * ADDR_W'(BYTES_PER_BEAT);
      remaining <= remaining - CNT_W'(burst_beats);
    end
  end

endmodule

// File: rtl/axi_wr_burst_master.sv
// rtl/axi_wr_burst_master.sv - writes a popped 64-bit beat stream as AXI4 INCR bursts
module axi_wr_burst_master
  import axi_wr_burst_master_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic [CNT_W-1:0]             total_beats,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  input  logic                         src_valid,
  input  logic [63:0]                  src_data,
  output logic                         src_rd_en,
  axi_wr_burst_master_if.master        m_axi
);

  state_e            state;
  state_e            next_state;
  logic [8:0]        beat_cnt;
  logic [ADDR_W-1:0] addr;
  logic [8:0]        burst_beats;
  logic [7:0]        awlen;
  logic              last_burst;
  logic              load;
  logic              advance;
  logic              awvalid;
  logic              wvalid;
  logic              wlast;
  logic              bready;

  assign load    = (state == ST_IDLE) && start && (total_beats != '0);
  assign advance = (state == ST_B) && m_axi.bvalid;

  axi_burst_splitter #(
    .ADDR_W    (ADDR_W),
    .BURST_LEN (BURST_LEN),
    .CNT_W     (CNT_W)
  ) u_splitter (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .advance     (advance),
    .base_addr   (base_addr),
    .total_beats (total_beats),
    .addr        (addr),
    .burst_beats (burst_beats),
    .awlen       (awlen),
    .last_burst  (last_burst)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state: one burst outstanding at a time, zero-length starts go straight to DONE.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: if (start) next_state = (total_beats != '0) ? ST_AW : ST_DONE;
      ST_AW:   if (m_axi.awready) next_state = ST_W;
      ST_W:    if (src_valid && m_axi.wready && (beat_cnt == 9'd1)) next_state = ST_B;
      ST_B:    if (m_axi.bvalid) next_state = last_burst ? ST_DONE : ST_AW;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs: W beats flow straight from the source, so wvalid tracks src_valid.
  always_comb begin
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    awvalid   = (state == ST_AW);
    wvalid    = (state == ST_W) && src_valid;
    wlast     = (state == ST_W) && (beat_cnt == 9'd1);
    bready    = (state == ST_B);
    src_rd_en = wvalid && m_axi.wready;
  end

  // Beats left in the current burst: loaded on the AW handshake, counted down per W handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (awvalid && m_axi.awready) begin
      beat_cnt <= burst_beats;
    end else if (src_rd_en) begin
      beat_cnt <= beat_cnt - 9'd1;
    end
  end

  // Sticky error flag: any non-OKAY response; cleared when a new start is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if ((state == ST_IDLE) && start) begin
      err <= 1'b0;
    end else if (advance && (m_axi.bresp != RESP_OKAY)) begin
      err <= 1'b1;
    end
  end

  assign m_axi.awaddr  = addr;
  assign m_axi.awlen   = awlen;
  assign m_axi.awsize  = AXSIZE_8B;
  assign m_axi.awburst = BURST_INCR;
  assign m_axi.awvalid = awvalid;
  assign m_axi.wdata   = src_data;
  assign m_axi.wstrb   = WSTRB_ALL;
  assign m_axi.wlast   = wlast;
  assign m_axi.wvalid  = wvalid;
  assign m_axi.bready  = bready;

endmodule

// File: tb/tb_axi_wr_burst_master.sv
// tb/tb_axi_wr_burst_master.sv - self-checking bench for axi_wr_burst_master
module tb_axi_wr_burst_master;

  localparam int ADDR_W    = 32;
  localparam int BURST_LEN = 16;
  localparam int CNT_W     = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] total_beats = '0;
  logic        busy, done, err;
  logic        src_valid = 1'b0;
  logic [63:0] src_data = '0;
  logic        src_rd_en;

  axi_wr_burst_master_if #(.ADDR_W(ADDR_W)) m_axi ();

  axi_wr_burst_master #(
    .ADDR_W    (ADDR_W),
    .BURST_LEN (BURST_LEN),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .total_beats (total_beats),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .src_rd_en   (src_rd_en),
    .m_axi       (m_axi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] base;
    int          beats;
    int          p_aw;
    int          p_w;
    int          p_src;
    int          err_burst;
    int          exp_bursts;
    logic        exp_err;
  } vec_t;

  int tests = 0;
  int fails = 0;

  logic [31:0] aw_addr_q[$];
  logic [7:0]  aw_len_q[$];
  logic [63:0] data_q[$];
  bit          wlast_q[$];
  int          hs, pops, done_cnt, viol;
  bit          timed_out, busy_after_start, err_after_start, err_at_done, err_idle, post_busy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one transfer as a randomised slave + source; records everything observed.
  task automatic run_xfer(input logic [31:0] base, input int beats, input int p_aw, input int p_w,
                          input int p_src, input int err_burst, input int abort_at);
    int          cyc = 0;
    int          src_idx = 0;
    int          bidx = 0;
    bit          src_hold = 0, pend_b = 0, aw_wait = 0, fin = 0, saw_done = 0;
    logic [31:0] held_addr = '0;
    logic [7:0]  held_len = '0;
    aw_addr_q.delete(); aw_len_q.delete(); data_q.delete(); wlast_q.delete();
    hs = 0; pops = 0; done_cnt = 0; viol = 0; timed_out = 0;
    busy_after_start = 0; err_after_start = 1; err_at_done = 0; err_idle = 0; post_busy = 1;
    while (!fin) begin
      @(negedge clk);
      if (cyc == 0) begin
        start = 1'b1; base_addr = base; total_beats = 16'(beats);
      end else begin
        start = ($urandom_range(0, 9) == 0);
        base_addr = $urandom; total_beats = 16'($urandom_range(0, 60));
      end
      if (!src_hold) src_valid = (int'($urandom_range(0, 99)) < p_src);
      src_data      = 64'(src_idx);
      m_axi.awready = (int'($urandom_range(0, 99)) < p_aw);
      m_axi.wready  = (int'($urandom_range(0, 99)) < p_w);
      m_axi.bvalid  = pend_b && (int'($urandom_range(0, 99)) < p_aw);
      m_axi.bresp   = (bidx == err_burst) ? 2'b10 : 2'b00;
      #1;
      if (cyc == 1) begin busy_after_start = busy; err_after_start = err; end
      if (m_axi.awvalid) begin
        if (aw_wait && (m_axi.awaddr != held_addr || m_axi.awlen != held_len)) viol++;
        if (m_axi.awready) begin
          aw_addr_q.push_back(m_axi.awaddr); aw_len_q.push_back(m_axi.awlen); aw_wait = 0;
        end else begin
          aw_wait = 1; held_addr = m_axi.awaddr; held_len = m_axi.awlen;
        end
      end else if (aw_wait) viol++;
      if (m_axi.wvalid && !src_valid) viol++;
      if (m_axi.wvalid && m_axi.wdata != src_data) viol++;
      if (src_rd_en != (m_axi.wvalid && m_axi.wready)) viol++;
      if (m_axi.wvalid && m_axi.wready) begin
        hs++; data_q.push_back(m_axi.wdata); wlast_q.push_back(m_axi.wlast);
        if (m_axi.wlast) pend_b = 1;
      end
      if (src_rd_en) begin pops++; src_idx++; src_hold = 0; end
      else src_hold = src_valid;
      if (m_axi.bvalid && m_axi.bready) begin pend_b = 0; bidx++; end
      if (done) begin done_cnt++; err_at_done = err; fin = 1; saw_done = 1; end
      if (abort_at > 0 && hs == abort_at) fin = 1;
      cyc++;
      if (!fin && cyc > 3000) begin timed_out = 1; fin = 1; end
    end
    if (saw_done) begin
      @(negedge clk);
      start = 1'b0; src_valid = 1'b0; m_axi.awready = 1'b0; m_axi.wready = 1'b0; m_axi.bvalid = 1'b0;
      #1;
      if (done) done_cnt++;
      post_busy = busy; err_idle = err;
    end
  endtask

  // Reference: bursts of up to BURST_LEN beats at base + n*BURST_LEN*8, data 0..beats-1 in order.
  task automatic check_xfer(input string nm, input logic [31:0] base, input int beats,
                            input int exp_bursts, input logic exp_err);
    int nb = (beats + BURST_LEN - 1) / BURST_LEN;
    int mism = 0;
    int lmism = 0;
    check({nm, ".timeout"}, 64'(timed_out), 0);
    check({nm, ".bursts"}, 64'(aw_addr_q.size()), 64'(exp_bursts));
    for (int i = 0; i < nb && i < aw_addr_q.size(); i++) begin
      logic [31:0] ea = base + 32'(i * BURST_LEN * 8);
      int left = beats - i * BURST_LEN;
      int el = ((left > BURST_LEN) ? BURST_LEN : left) - 1;
      check($sformatf("%s.awaddr%0d", nm, i), 64'(aw_addr_q[i]), 64'(ea));
      check($sformatf("%s.awlen%0d", nm, i), 64'(aw_len_q[i]), 64'(el));
    end
    for (int k = 0; k < data_q.size(); k++) begin
      if (data_q[k] != 64'(k)) mism++;
      if (wlast_q[k] != (((k + 1) % BURST_LEN == 0) || (k == beats - 1))) lmism++;
    end
    check({nm, ".beats"}, 64'(hs), 64'(beats));
    check({nm, ".pops"}, 64'(pops), 64'(beats));
    check({nm, ".data_order_errs"}, 64'(mism), 0);
    check({nm, ".wlast_errs"}, 64'(lmism), 0);
    check({nm, ".protocol_errs"}, 64'(viol), 0);
    check({nm, ".busy_after_start"}, 64'(busy_after_start), 1);
    check({nm, ".err_cleared_on_start"}, 64'(err_after_start), 0);
    check({nm, ".err_at_done"}, 64'(err_at_done), 64'(exp_err));
    check({nm, ".err_sticky_idle"}, 64'(err_idle), 64'(exp_err));
    check({nm, ".done_pulses"}, 64'(done_cnt), 1);
    check({nm, ".busy_after_done"}, 64'(post_busy), 0);
  endtask

  initial begin
    vec_t vecs[7];
    int   done_at;
    int   dcnt;
    bit   saw_aw, saw_pop;

    vecs[0] = '{32'h0000_1000, 16, 100, 100, 100, -1, 1, 1'b0};
    vecs[1] = '{32'h0000_2000, 40, 100, 100, 100, -1, 3, 1'b0};
    vecs[2] = '{32'h0000_3000, 20,  40,  50,  60, -1, 2, 1'b0};
    vecs[3] = '{32'h0000_4000, 48,  70,  80,  90,  1, 3, 1'b1};
    vecs[4] = '{32'h0000_4800,  1, 100, 100, 100, -1, 1, 1'b0};
    vecs[5] = '{32'hFFFF_FF80, 24,  60,  70,  80, -1, 2, 1'b0};
    vecs[6] = '{32'h0001_0000, 17,  50,  50,  50,  1, 2, 1'b1};

    m_axi.awready = 1'b0; m_axi.wready = 1'b0; m_axi.bvalid = 1'b0; m_axi.bresp = 2'b00;
    src_valid = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst.ctrl", {busy, done, err, src_rd_en}, 0);
    check("rst.valids", {m_axi.awvalid, m_axi.wvalid, m_axi.wlast, m_axi.bready}, 0);
    check("rst.awaddr", 64'(m_axi.awaddr), 0);
    check("rst.awlen", 64'(m_axi.awlen), 0);
    check("const.awsize", 64'(m_axi.awsize), 64'h3);
    check("const.awburst", 64'(m_axi.awburst), 64'h1);
    check("const.wstrb", 64'(m_axi.wstrb), 64'hFF);
    @(negedge clk);
    rst_n = 1'b1; src_valid = 1'b0;

    for (int v = 0; v < 7; v++) begin
      run_xfer(vecs[v].base, vecs[v].beats, vecs[v].p_aw, vecs[v].p_w, vecs[v].p_src, vecs[v].err_burst, 0);
      check_xfer($sformatf("vec%0d", v), vecs[v].base, vecs[v].beats, vecs[v].exp_bursts, vecs[v].exp_err);
    end

    for (int r = 0; r < 6; r++) begin
      logic [31:0] b  = $urandom & 32'hFFFF_FF80;
      int          n  = int'($urandom_range(1, 70));
      int          eb = int'($urandom_range(0, 5));
      int          nb = (n + BURST_LEN - 1) / BURST_LEN;
      run_xfer(b, n, int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
               int'($urandom_range(30, 100)), eb, 0);
      check_xfer($sformatf("rand%0d", r), b, n, nb, eb < nb);
    end

    // Zero-length transfer: done only, no AXI traffic, no pops.
    done_at = -1; dcnt = 0; saw_aw = 0; saw_pop = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = (i == 0); base_addr = 32'h7000; total_beats = 16'd0;
      src_valid = 1'b1; m_axi.awready = 1'b1; m_axi.wready = 1'b1; m_axi.bvalid = 1'b0;
      #1;
      if (m_axi.awvalid) saw_aw = 1;
      if (src_rd_en) saw_pop = 1;
      if (done) begin dcnt++; if (done_at < 0) done_at = i; end
    end
    check("zero.done_count", 64'(dcnt), 1);
    check("zero.done_within_2", 64'(done_at >= 1 && done_at <= 2), 1);
    check("zero.no_awvalid", 64'(saw_aw), 0);
    check("zero.no_pop", 64'(saw_pop), 0);
    @(negedge clk);
    src_valid = 1'b0;

    // Reset while streaming beat 5 of 16: outputs must clear without a clock edge.
    run_xfer(32'h0000_5000, 16, 100, 100, 100, -1, 5);
    check("rstw.reached_beat5", 64'(hs), 5);
    @(negedge clk);
    start = 1'b0; src_valid = 1'b1; m_axi.wready = 1'b0; m_axi.awready = 1'b1;
    #1;
    check("rstw.pre_wvalid", 64'(m_axi.wvalid), 1);
    rst_n = 1'b0;
    #1;
    check("rstw.valids", {m_axi.awvalid, m_axi.wvalid, m_axi.bready, src_rd_en}, 0);
    check("rstw.ctrl", {busy, done, err}, 0);
    check("rstw.awaddr", 64'(m_axi.awaddr), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; src_valid = 1'b0;
    run_xfer(32'h0000_6000, 4, 100, 100, 100, -1, 0);
    check_xfer("after_rst", 32'h0000_6000, 4, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
